// File: rtl/instr_fetch_decode.sv
// Front end of the single-cycle RISC-V datapath: fetches over a req/valid
// handshake, decodes into the control bundle, issues once, resolves beq, traps.
module instr_fetch_decode #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT    = 16
) (
  input  logic        CLK,
  input  logic        ResetPC,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  input  logic        IMemValid,
  input  logic        Zero,
  output logic [31:0] Instruction,
  output logic        IssueValid,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        MemToReg,
  output logic        Branch,
  output logic [3:0]  ALUControl,
  output logic        Halted,
  output logic [1:0]  TrapCause,
  output logic [31:0] RetiredCount
);

  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_TRAP} state_e;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  localparam logic [3:0] ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                         ALU_OR   = 4'd3, ALU_SLL = 4'd4, ALU_SLT = 4'd5,
                         ALU_XOR  = 4'd6, ALU_SRL = 4'd7, ALU_SLTU = 4'd8,
                         ALU_LUI  = 4'd9;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1, CAUSE_MISALIGN = 2'd2, CAUSE_TIMEOUT = 2'd3;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  // Returns 1 for a supported encoding; controls come back all-zero otherwise.
  function automatic logic decode(input logic [31:0] w, output ctrl_t c);
    logic       ok;
    logic [2:0] f3;
    logic [6:0] f7;
    ok = 1'b0;
    c  = '0;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      7'b0110011: begin
        c.reg_write = 1'b1;
        ok = (f7 == 7'b0000000);
        case (f3)
          3'b000: begin
            ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            c.alu_ctrl = (f7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
          end
          3'b111: c.alu_ctrl = ALU_AND;
          3'b110: c.alu_ctrl = ALU_OR;
          3'b001: c.alu_ctrl = ALU_SLL;
          3'b010: c.alu_ctrl = ALU_SLT;
          3'b100: c.alu_ctrl = ALU_XOR;
          3'b101: c.alu_ctrl = ALU_SRL;
          default: c.alu_ctrl = ALU_SLTU;
        endcase
      end
      7'b0010011: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        ok = 1'b1;
        case (f3)
          3'b000: c.alu_ctrl = ALU_ADD;
          3'b111: c.alu_ctrl = ALU_AND;
          3'b110: c.alu_ctrl = ALU_OR;
          3'b100: c.alu_ctrl = ALU_XOR;
          3'b010: c.alu_ctrl = ALU_SLT;
          3'b011: c.alu_ctrl = ALU_SLTU;
          3'b001: begin c.alu_ctrl = ALU_SLL; ok = (f7 == 7'b0000000); end
          default: begin c.alu_ctrl = ALU_SRL; ok = (f7 == 7'b0000000); end
        endcase
      end
      7'b0000011: begin
        ok = (f3 == 3'b010);
        c.reg_write  = 1'b1;
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      7'b0100011: begin
        ok = (f3 == 3'b010);
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      7'b0110111: begin
        ok = 1'b1;
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_ctrl  = ALU_LUI;
      end
      7'b1100011: begin
        ok = (f3 == 3'b000);
        c.branch   = 1'b1;
        c.alu_ctrl = ALU_SUB;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) c = '0;
    return ok;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] instr_q, instr_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] retired_q, retired_d;

  ctrl_t       dec_ctrl;
  logic        dec_ok;
  logic [31:0] b_imm, pc_next;

  always_ff @(posedge CLK or posedge ResetPC) begin
    if (ResetPC) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_ADDR;
      tmo_q     <= '0;
      instr_q   <= '0;
      ctrl_q    <= '0;
      cause_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tmo_q     <= tmo_d;
      instr_q   <= instr_d;
      ctrl_q    <= ctrl_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tmo_d     = tmo_q;
    instr_d   = instr_q;
    ctrl_d    = ctrl_q;
    cause_d   = cause_q;
    retired_d = retired_q;
    dec_ok    = decode(IMemData, dec_ctrl);
    b_imm     = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    pc_next   = (ctrl_q.branch && Zero) ? (pc_q + b_imm) : (pc_q + 32'd4);
    case (state_q)
      S_FETCH: begin
        if (IMemValid) begin
          instr_d = IMemData;
          ctrl_d  = dec_ctrl;
          if (dec_ok) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q == TMO_LAST) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      S_ISSUE: begin
        retired_d = retired_q + 32'd1;
        tmo_d     = '0;
        // A misaligned target traps with the PC left on the branch itself.
        if (pc_next[1:0] != 2'b00) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MISALIGN;
        end else begin
          pc_d    = pc_next;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_TRAP;
    endcase
  end

  always_comb begin
    IssueValid   = (state_q == S_ISSUE);
    IMemReq      = (state_q == S_FETCH) && !ResetPC;
    IMemAddr     = pc_q;
    Instruction  = instr_q;
    Halted       = (state_q == S_TRAP);
    TrapCause    = cause_q;
    RetiredCount = retired_q;
    RegWrite     = IssueValid & ctrl_q.reg_write;
    ALUSrc       = IssueValid & ctrl_q.alu_src;
    MemWrite     = IssueValid & ctrl_q.mem_write;
    MemRead      = IssueValid & ctrl_q.mem_read;
    MemToReg     = IssueValid & ctrl_q.mem_to_reg;
    Branch       = IssueValid & ctrl_q.branch;
    ALUControl   = IssueValid ? ctrl_q.alu_ctrl : 4'd0;
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: hand-computed fetch/issue/branch/trap cases.
module tb_instr_fetch_decode;

  logic        CLK = 1'b0;
  logic        ResetPC;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic        IMemValid;
  logic        Zero;
  logic [31:0] Instruction;
  logic        IssueValid, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch;
  logic [3:0]  ALUControl;
  logic        Halted;
  logic [1:0]  TrapCause;
  logic [31:0] RetiredCount;

  int checks = 0;
  int errors = 0;

  instr_fetch_decode dut (
    .CLK(CLK), .ResetPC(ResetPC), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemData(IMemData), .IMemValid(IMemValid), .Zero(Zero),
    .Instruction(Instruction), .IssueValid(IssueValid), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg),
    .Branch(Branch), .ALUControl(ALUControl), .Halted(Halted),
    .TrapCause(TrapCause), .RetiredCount(RetiredCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {IssueValid, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch, ALUControl}
  function automatic logic [31:0] ctrl_vec();
    return {21'd0, IssueValid, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch, ALUControl};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called #1 after an edge with the DUT in FETCH; returns in the cycle after the strobe.
  task automatic deliver(input logic [31:0] w, input int waits);
    for (int i = 0; i < waits; i++) begin
      chk("req_held", {31'd0, IMemReq}, 32'd1);
      step();
    end
    IMemData  = w;
    IMemValid = 1'b1;
    step();
    IMemValid = 1'b0;
    IMemData  = 32'h0;
  endtask

  task automatic do_reset();
    #2;
    ResetPC = 1'b1;
    step();
    ResetPC = 1'b0;
  endtask

  initial begin
    ResetPC   = 1'b1;
    IMemValid = 1'b0;
    IMemData  = 32'h0;
    Zero      = 1'b0;
    #3;
    chk("rst_req",     {31'd0, IMemReq}, 32'd0);
    chk("rst_ctrl",    ctrl_vec(), 32'h0);
    chk("rst_halted",  {31'd0, Halted}, 32'd0);
    chk("rst_cause",   {30'd0, TrapCause}, 32'd0);
    chk("rst_retired", RetiredCount, 32'd0);
    chk("rst_instr",   Instruction, 32'd0);
    step();
    ResetPC = 1'b0;
    #1;
    chk("req_after_rst", {31'd0, IMemReq}, 32'd1);
    chk("addr_after_rst", IMemAddr, 32'h0);

    // add x1,x3,x2 at PC 0, valid one cycle after request
    deliver(32'h002180B3, 1);
    chk("add_ctrl",  ctrl_vec(), 32'b1_1_0_0_0_0_0_0000);
    chk("add_instr", Instruction, 32'h002180B3);
    step();
    chk("add_one_cycle", {31'd0, IssueValid}, 32'd0);
    chk("add_pc", IMemAddr, 32'h4);
    chk("add_retired", RetiredCount, 32'd1);

    // lw with 5-cycle memory latency
    deliver(32'h01412703, 4);
    chk("lw_ctrl", ctrl_vec(), 32'b1_1_1_0_1_1_0_0000);
    chk("lw_halted", {31'd0, Halted}, 32'd0);
    step();
    chk("lw_pc", IMemAddr, 32'h8);

    // beq at PC 8, imm 0x14, taken
    deliver(32'h00228A63, 0);
    chk("beq_ctrl", ctrl_vec(), 32'b1_0_0_0_0_0_1_0001);
    Zero = 1'b1;
    step();
    Zero = 1'b0;
    chk("beq_taken_pc", IMemAddr, 32'h1C);

    // beq at 0x1C, imm 0x24, taken -> 0x40
    deliver(32'h02000263, 0);
    Zero = 1'b1;
    step();
    Zero = 1'b0;
    chk("beq2_pc", IMemAddr, 32'h40);
    chk("beq2_retired", RetiredCount, 32'd4);
    step();
    step();
    chk("fetch40_req", {31'd0, IMemReq}, 32'd1);

    // asynchronous reset mid-FETCH, with a stray strobe while in reset
    #2;
    ResetPC   = 1'b1;
    IMemValid = 1'b1;
    IMemData  = 32'h002180B3;
    #1;
    chk("midrst_req", {31'd0, IMemReq}, 32'd0);
    chk("midrst_addr", IMemAddr, 32'h0);
    chk("midrst_retired", RetiredCount, 32'd0);
    step();
    IMemValid = 1'b0;
    IMemData  = 32'h0;
    ResetPC   = 1'b0;
    #1;
    chk("midrst_fetch_addr", IMemAddr, 32'h0);
    chk("midrst_ignored", ctrl_vec(), 32'h0);
    chk("midrst_req_back", {31'd0, IMemReq}, 32'd1);

    // beq not taken at PC 8 -> 0x0C
    deliver(32'h002180B3, 0);
    step();
    deliver(32'h01412703, 0);
    step();
    deliver(32'h00228A63, 0);
    Zero = 1'b0;
    step();
    chk("beq_nt_pc", IMemAddr, 32'h0C);
    chk("beq_nt_retired", RetiredCount, 32'd3);

    // taken beq with imm 2 -> misaligned trap, PC unchanged, issue still counted
    deliver(32'h00000163, 0);
    Zero = 1'b1;
    step();
    Zero = 1'b0;
    chk("mis_halted", {31'd0, Halted}, 32'd1);
    chk("mis_cause", {30'd0, TrapCause}, 32'd2);
    chk("mis_pc", IMemAddr, 32'h0C);
    chk("mis_retired", RetiredCount, 32'd4);
    chk("mis_req", {31'd0, IMemReq}, 32'd0);

    // other legal decodes: sub, srli, sw, lui
    do_reset();
    deliver(32'h402180B3, 0);
    chk("sub_ctrl", ctrl_vec(), 32'b1_1_0_0_0_0_0_0001);
    step();
    deliver(32'h0030D093, 0);
    chk("srli_ctrl", ctrl_vec(), 32'b1_1_1_0_0_0_0_0111);
    step();
    deliver(32'h00E12A23, 0);
    chk("sw_ctrl", ctrl_vec(), 32'b1_0_1_1_0_0_0_0000);
    step();
    deliver(32'h000010B7, 0);
    chk("lui_ctrl", ctrl_vec(), 32'b1_1_1_0_0_0_0_1001);
    step();
    chk("seq_pc", IMemAddr, 32'h10);
    chk("seq_retired", RetiredCount, 32'd4);

    // all-zero word is illegal; stays halted with strobes ignored
    do_reset();
    deliver(32'h00000000, 0);
    chk("ill_issue", ctrl_vec(), 32'h0);
    chk("ill_halted", {31'd0, Halted}, 32'd1);
    chk("ill_cause", {30'd0, TrapCause}, 32'd1);
    chk("ill_retired", RetiredCount, 32'd0);
    IMemValid = 1'b1;
    IMemData  = 32'h002180B3;
    step();
    step();
    IMemValid = 1'b0;
    chk("ill_req_stays0", {31'd0, IMemReq}, 32'd0);
    chk("ill_still_halted", {31'd0, Halted}, 32'd1);

    // srai (f7=0100000) is illegal
    do_reset();
    deliver(32'h4030D093, 0);
    chk("srai_cause", {30'd0, TrapCause}, 32'd1);

    // R-type with f7=0000001 is illegal
    do_reset();
    deliver(32'h022180B3, 0);
    chk("rf7_cause", {30'd0, TrapCause}, 32'd1);

    // fetch timeout after 16 cycles without a strobe
    do_reset();
    #1;
    repeat (15) step();
    chk("tmo_not_yet", {31'd0, Halted}, 32'd0);
    chk("tmo_req_15", {31'd0, IMemReq}, 32'd1);
    step();
    chk("tmo_halted", {31'd0, Halted}, 32'd1);
    chk("tmo_cause", {30'd0, TrapCause}, 32'd3);
    chk("tmo_req", {31'd0, IMemReq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
